// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arb_pkg
//  Purpose  : Shared types and helpers for the program/data memory arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic {
        OWN_DATA = 1'b0,
        OWN_PROG = 1'b1
    } owner_t;

    // Latency counter width; never below one bit.
    function automatic int lat_cnt_w(input int lat);
        return (lat < 1) ? 1 : $clog2(lat + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arb_grant.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arb_grant
//  Purpose  : Data-priority grant decision with bounded fetch starvation.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_arb_grant #(
    parameter int MAX_DATA_BURST = 4
) (
    input  logic CLK,
    input  logic reset,
    input  logic CS,
    input  logic CS_P,
    input  logic grant_en,
    output logic grant_prog
);

    localparam int c_streak_w = (MAX_DATA_BURST < 1) ? 1 : $clog2(MAX_DATA_BURST + 1);
    localparam logic [c_streak_w-1:0] c_streak_max = c_streak_w'(MAX_DATA_BURST);

    logic [c_streak_w-1:0] r_streak;

    // Fetch wins when alone, or when data has used up its burst allowance.
    assign grant_prog = CS_P && (!CS || (r_streak == c_streak_max));

    always_ff @(posedge CLK) begin
        if (!reset) begin
            r_streak <= '0;
        end else if (grant_en) begin
            if (grant_prog) begin
                r_streak <= '0;
            end else if (CS_P && (r_streak != c_streak_max)) begin
                r_streak <= r_streak + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_bus_arbiter
//  Purpose  : Serialises CPU fetch and data ports onto one single-ported memory.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int MEM_LAT        = 2,
    parameter int MAX_DATA_BURST = 4
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              CS,
    input  logic              WE,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [DATA_W-1:0] Data_BUS_WRITE,
    output logic [DATA_W-1:0] Data_BUS_READ,
    output logic              d_ready,
    input  logic              CS_P,
    input  logic [ADDR_W-1:0] ADDR_Prog,
    output logic [DATA_W-1:0] Prog_BUS_READ,
    output logic              p_ready,
    output logic              mem_cs,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int c_cnt_w = lat_cnt_w(MEM_LAT);
    localparam logic [c_cnt_w-1:0] c_cnt_init = c_cnt_w'(MEM_LAT - 1);

    state_t              r_state;
    owner_t              r_owner;
    logic                r_we;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [DATA_W-1:0]   r_dbus;
    logic [DATA_W-1:0]   r_pbus;
    logic                r_d_ready;
    logic                r_p_ready;
    logic                r_mem_cs;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;

    logic w_grant_en;
    logic w_grant_prog;

    assign w_grant_en = (r_state == ST_IDLE) && (CS || CS_P);

    mem_arb_grant #(
        .MAX_DATA_BURST (MAX_DATA_BURST)
    ) u_grant (
        .CLK        (CLK),
        .reset      (reset),
        .CS         (CS),
        .CS_P       (CS_P),
        .grant_en   (w_grant_en),
        .grant_prog (w_grant_prog)
    );

    always_ff @(posedge CLK) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_owner     <= OWN_DATA;
            r_we        <= 1'b0;
            r_cnt       <= '0;
            r_dbus      <= '0;
            r_pbus      <= '0;
            r_d_ready   <= 1'b0;
            r_p_ready   <= 1'b0;
            r_mem_cs    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_en) begin
                        r_owner     <= w_grant_prog ? OWN_PROG : OWN_DATA;
                        r_we        <= !w_grant_prog && WE;
                        r_mem_cs    <= 1'b1;
                        r_mem_we    <= !w_grant_prog && WE;
                        r_mem_addr  <= w_grant_prog ? ADDR_Prog : ADDR;
                        r_mem_wdata <= Data_BUS_WRITE;
                        r_state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_mem_cs <= 1'b0;
                    r_mem_we <= 1'b0;
                    if (r_we) begin
                        r_d_ready <= 1'b1;
                        r_state   <= ST_DONE;
                    end else begin
                        r_cnt   <= c_cnt_init;
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // Leaving WAIT is the edge on which mem_rdata is valid.
                    if (r_cnt == '0) begin
                        if (r_owner == OWN_PROG) begin
                            r_pbus    <= mem_rdata;
                            r_p_ready <= 1'b1;
                        end else begin
                            r_dbus    <= mem_rdata;
                            r_d_ready <= 1'b1;
                        end
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    r_d_ready <= 1'b0;
                    r_p_ready <= 1'b0;
                    r_state   <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign Data_BUS_READ = r_dbus;
    assign Prog_BUS_READ = r_pbus;
    assign d_ready       = r_d_ready;
    assign p_ready       = r_p_ready;
    assign mem_cs        = r_mem_cs;
    assign mem_we        = r_mem_we;
    assign mem_addr      = r_mem_addr;
    assign mem_wdata     = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_bus_arbiter
//  Purpose  : Scoreboard bench for mem_bus_arbiter with latency sweep copies.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_bus_arbiter;

    logic clk = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   sweep_cnt = 0;

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mval(input logic [7:0] a);
        if (a == 8'h04) return 32'h0000_064f;
        return {16'hC0DE, a, ~a};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- main instance, MEM_LAT = 2 ----------------
    logic        rst_n, cs, we, cs_p, d_ready, p_ready, mem_cs, mem_we;
    logic [31:0] addr, wdata, addr_p, dbus, pbus, mem_addr, mem_wdata, mem_rdata;

    mem_bus_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .MAX_DATA_BURST(4)
    ) u_dut (
        .CLK(clk), .reset(rst_n), .CS(cs), .WE(we), .ADDR(addr),
        .Data_BUS_WRITE(wdata), .Data_BUS_READ(dbus), .d_ready(d_ready),
        .CS_P(cs_p), .ADDR_Prog(addr_p), .Prog_BUS_READ(pbus), .p_ready(p_ready),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    logic [31:0] mem0 [256];
    logic [1:0]  pv0 = 2'b00;
    logic [7:0]  pa0 [2];

    initial for (int i = 0; i < 256; i++) mem0[i] = mval(8'(i));

    always @(posedge clk) begin
        pv0    <= {pv0[0], mem_cs && !mem_we};
        pa0[1] <= pa0[0];
        pa0[0] <= mem_addr[7:0];
        if (mem_cs && mem_we) mem0[mem_addr[7:0]] <= mem_wdata;
    end
    assign mem_rdata = pv0[1] ? mem0[pa0[1]] : 32'hBAD0_BAD0;

    // ---------------- scoreboard ----------------
    typedef struct {
        bit          prog;
        bit          is_read;
        logic [31:0] data;
        int          lat;
        int          start;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [31:0] m_dbus = '0;
    logic [31:0] m_pbus = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_dbus = '0;
            m_pbus = '0;
        end else begin
            check("mem_we without mem_cs", mem_we & ~mem_cs, 0);
            if (d_ready || p_ready) begin
                check("both ready", d_ready & p_ready, 0);
                if (exp_q.size() == 0) begin
                    check("unexpected ready", {p_ready, d_ready}, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("ready owner", {p_ready, d_ready}, mon_e.prog ? 2'b10 : 2'b01);
                    if (mon_e.is_read) begin
                        if (mon_e.prog) m_pbus = mon_e.data;
                        else            m_dbus = mon_e.data;
                    end
                    check("Data_BUS_READ", dbus, m_dbus);
                    check("Prog_BUS_READ", pbus, m_pbus);
                    if (mon_e.lat >= 0) check("ready latency", cyc - mon_e.start, mon_e.lat);
                end
            end
        end
    end

    task automatic push(input bit prog, input bit rd, input logic [31:0] d, input int lat);
        exp_t e;
        e.prog = prog; e.is_read = rd; e.data = d; e.lat = lat; e.start = cyc;
        exp_q.push_back(e);
    endtask

    // Issue one request in an IDLE cycle, check the strobe cycle, wait for ready.
    task automatic xfer(input bit prog, input bit wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] exp_d, input int lat);
        int k;
        if (prog) begin cs_p = 1'b1; addr_p = a; end
        else      begin cs = 1'b1; we = wr; addr = a; wdata = wd; end
        push(prog, prog || !wr, exp_d, lat);
        tick();
        check(prog ? "fetch mem_cs/we" : "data mem_cs/we", {mem_cs, mem_we}, {1'b1, wr && !prog});
        check("mem_addr", mem_addr, a);
        if (wr && !prog) check("mem_wdata", mem_wdata, wd);
        k = 0;
        while (!(d_ready || p_ready) && k < 30) begin
            tick();
            if (prog) check("fetch mem_we", mem_we, 0);
            k++;
        end
        if (k >= 30) check("ready timeout", d_ready || p_ready, 1);
        tick();
        cs = 1'b0; cs_p = 1'b0; we = 1'b0;
    endtask

    initial begin
        int k;
        rst_n = 1'b0; cs = 1'b1; we = 1'b1; addr = 32'h10; wdata = 32'h22b4;
        cs_p = 1'b0; addr_p = '0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("reset ctrl", {d_ready, p_ready, mem_cs, mem_we}, 0);
            check("reset buses", mem_addr | mem_wdata | dbus | pbus, 0);
        end
        rst_n = 1'b1;
        xfer(1'b0, 1'b1, 32'h10, 32'h22b4, 32'h0, 2);
        xfer(1'b1, 1'b0, 32'h4, 32'h0, 32'h064f, 4);
        xfer(1'b0, 1'b0, 32'h20, 32'h0, mval(8'h20), 4);
        xfer(1'b0, 1'b1, 32'h14, 32'h5555, 32'h0, 2);
        xfer(1'b0, 1'b0, 32'h10, 32'h0, 32'h22b4, 4);
        xfer(1'b0, 1'b0, 32'h14, 32'h0, 32'h5555, 4);

        // Both ports held: D D D D P D D D D P
        cs = 1'b1; we = 1'b0; addr = 32'h20; cs_p = 1'b1; addr_p = 32'h8;
        for (int r = 0; r < 2; r++) begin
            for (int d = 0; d < 4; d++) push(1'b0, 1'b1, mval(8'h20), -1);
            push(1'b1, 1'b1, mval(8'h08), -1);
        end
        k = 0;
        while (exp_q.size() > 0 && k < 200) begin tick(); k++; end
        if (k >= 200) check("burst timeout", exp_q.size(), 0);
        cs = 1'b0; cs_p = 1'b0;

        // Reset during WAIT of a data read
        cs = 1'b1; we = 1'b0; addr = 32'h30;
        tick();
        tick();
        rst_n = 1'b0; cs = 1'b0;
        tick();
        check("mid-wait reset ctrl", {d_ready, p_ready, mem_cs, mem_we}, 0);
        check("mid-wait reset Data_BUS_READ", dbus, 0);
        check("mid-wait reset mem_addr", mem_addr, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("abandoned read ready", {d_ready, p_ready}, 0);
        end
        xfer(1'b0, 1'b0, 32'h10, 32'h0, 32'h22b4, 4);

        k = 0;
        while (sweep_cnt < 2 && k < 500) begin tick(); k++; end
        check("sweep completion", sweep_cnt, 2);
        check("scoreboard drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // ---------------- latency sweep: MEM_LAT = 1 and 5 ----------------
    for (genvar gi = 0; gi < 2; gi++) begin : g_sweep
        localparam int LAT = (gi == 0) ? 1 : 5;

        logic        s_rst, s_cs, s_d_ready, s_p_ready, s_mem_cs, s_mem_we;
        logic [31:0] s_dbus, s_pbus, s_mem_addr, s_mem_wdata, s_mem_rdata;
        logic [31:0] s_mem [256];
        logic [LAT-1:0] s_pv = '0;
        logic [7:0]  s_pa [LAT];
        int          n_rdy = 0;
        int          last = 0;

        mem_bus_arbiter #(
            .ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .MAX_DATA_BURST(4)
        ) u_dut (
            .CLK(clk), .reset(s_rst), .CS(s_cs), .WE(1'b0), .ADDR(32'h40),
            .Data_BUS_WRITE(32'h0), .Data_BUS_READ(s_dbus), .d_ready(s_d_ready),
            .CS_P(1'b0), .ADDR_Prog(32'h0), .Prog_BUS_READ(s_pbus), .p_ready(s_p_ready),
            .mem_cs(s_mem_cs), .mem_we(s_mem_we), .mem_addr(s_mem_addr),
            .mem_wdata(s_mem_wdata), .mem_rdata(s_mem_rdata)
        );

        initial for (int i = 0; i < 256; i++) s_mem[i] = mval(8'(i));

        always @(posedge clk) begin
            for (int k = LAT - 1; k > 0; k--) begin
                s_pv[k] <= s_pv[k-1];
                s_pa[k] <= s_pa[k-1];
            end
            s_pv[0] <= s_mem_cs && !s_mem_we;
            s_pa[0] <= s_mem_addr[7:0];
        end
        assign s_mem_rdata = s_pv[LAT-1] ? s_mem[s_pa[LAT-1]] : 32'hBAD0_BAD0;

        always @(negedge clk) begin
            if (s_rst && (s_d_ready || s_p_ready)) begin
                check($sformatf("lat%0d read data", LAT), {s_p_ready, s_dbus}, {1'b0, 32'hC0DE_40BF});
                check($sformatf("lat%0d ready spacing", LAT), cyc - last,
                      (n_rdy == 0) ? LAT + 2 : LAT + 3);
                last = cyc;
                n_rdy++;
            end
        end

        initial begin
            int k;
            s_rst = 1'b0; s_cs = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            s_rst = 1'b1; s_cs = 1'b1; last = cyc;
            k = 0;
            while (n_rdy < 4 && k < 100) begin @(posedge clk); k++; end
            #1;
            s_cs = 1'b0;
            if (k >= 100) check($sformatf("lat%0d ready count", LAT), n_rdy, 4);
            sweep_cnt++;
        end
    end

endmodule
`default_nettype wire
